// File: rtl/dual_beam_thresh_trigger_pkg.sv
// ============================================================================
// Module   : dual_beam_pkg
// Brief    : Shared widths, reset threshold and beam index constants for the
//            two-beam threshold trigger.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dual_beam_pkg;

  localparam int INPUT_WIDTH  = 17;
  localparam int THRESH_WIDTH = INPUT_WIDTH + 1;

  // All-ones threshold sits above the largest possible sum (0x3FFFE), so a
  // freshly reset beam can never fire until a real threshold is loaded.
  localparam logic [THRESH_WIDTH-1:0] THRESH_RESET = 18'h3FFFF;

  // Bit positions of each beam within thresh_ce_i / trigger_o
  localparam int BEAM_A = 1;
  localparam int BEAM_B = 0;

endpackage : dual_beam_pkg

`default_nettype wire

// File: rtl/dual_beam_thresh_trigger_slice.sv
// ============================================================================
// Module   : beam_thresh_slice
// Brief    : One beam of the threshold trigger: input register, adder, sum
//            register, shadow/active threshold pair and registered compare.
//            Latency from inputs to trigger is three clocks.
//            Optional macro DUAL_BEAM_GE_EN turns the compare into >=.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module beam_thresh_slice
  import dual_beam_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [INPUT_WIDTH-1:0]  in0_i,
  input  logic [INPUT_WIDTH-1:0]  in1_i,
  input  logic [THRESH_WIDTH-1:0] thresh_i,
  input  logic                    thresh_ce_i,
  input  logic                    update_i,
  output logic                    trigger_o
);

  logic [INPUT_WIDTH-1:0]  r_in0;
  logic [INPUT_WIDTH-1:0]  r_in1;
  logic [THRESH_WIDTH-1:0] r_sum;
  logic [THRESH_WIDTH-1:0] r_shadow;
  logic [THRESH_WIDTH-1:0] r_active;
  logic                    r_trig;
  logic [THRESH_WIDTH-1:0] w_sum;
  logic                    w_hit;

  // Zero-extended add; one extra bit means the sum can never wrap
  assign w_sum = {1'b0, r_in0} + {1'b0, r_in1};

`ifdef DUAL_BEAM_GE_EN
  assign w_hit = (r_sum >= r_active);
`else
  assign w_hit = (r_sum > r_active);
`endif

  // Three-stage datapath: inputs, sum, compare result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_in0  <= '0;
      r_in1  <= '0;
      r_sum  <= '0;
      r_trig <= 1'b0;
    end else begin
      r_in0  <= in0_i;
      r_in1  <= in1_i;
      r_sum  <= w_sum;
      r_trig <= w_hit;
    end
  end

  // Shadow/active threshold double buffer; update copies the pre-edge shadow
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_shadow <= THRESH_RESET;
      r_active <= THRESH_RESET;
    end else begin
      if (thresh_ce_i) r_shadow <= thresh_i;
      if (update_i)    r_active <= r_shadow;
    end
  end

  assign trigger_o = r_trig;

endmodule : beam_thresh_slice

`default_nettype wire

// File: rtl/dual_beam_thresh_trigger.sv
// ============================================================================
// Module   : dual_beam_thresh_trigger
// Brief    : Two-beam threshold trigger. Each beam sums two unsigned 17-bit
//            partial sums and compares against its own double-buffered
//            threshold; triggers appear three clocks after the inputs.
//            Optional macro DUAL_BEAM_GE_EN selects a >= compare.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dual_beam_thresh_trigger
  import dual_beam_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [INPUT_WIDTH-1:0]  beamA_in0_i,
  input  logic [INPUT_WIDTH-1:0]  beamA_in1_i,
  input  logic [INPUT_WIDTH-1:0]  beamB_in0_i,
  input  logic [INPUT_WIDTH-1:0]  beamB_in1_i,
  input  logic [THRESH_WIDTH-1:0] thresh_i,
  input  logic [1:0]              thresh_ce_i,
  input  logic                    update_i,
  output logic [1:0]              trigger_o
);

  beam_thresh_slice u_beam_a (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in0_i       (beamA_in0_i),
    .in1_i       (beamA_in1_i),
    .thresh_i    (thresh_i),
    .thresh_ce_i (thresh_ce_i[BEAM_A]),
    .update_i    (update_i),
    .trigger_o   (trigger_o[BEAM_A])
  );

  beam_thresh_slice u_beam_b (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in0_i       (beamB_in0_i),
    .in1_i       (beamB_in1_i),
    .thresh_i    (thresh_i),
    .thresh_ce_i (thresh_ce_i[BEAM_B]),
    .update_i    (update_i),
    .trigger_o   (trigger_o[BEAM_B])
  );

endmodule : dual_beam_thresh_trigger

`default_nettype wire

// File: tb/tb_dual_beam_thresh_trigger.sv
// ============================================================================
// Module   : tb_dual_beam_thresh_trigger
// Brief    : Directed self-checking bench for dual_beam_thresh_trigger
//            (default build: strict greater-than compare).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dual_beam_thresh_trigger;

  logic        clk;
  logic        rst_n;
  logic [16:0] a0, a1, b0, b1;
  logic [17:0] thresh;
  logic [1:0]  ce;
  logic        upd;
  logic [1:0]  trig;

  int n_cmp;
  int n_bad;

  dual_beam_thresh_trigger dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .beamA_in0_i (a0),
    .beamA_in1_i (a1),
    .beamB_in0_i (b0),
    .beamB_in1_i (b1),
    .thresh_i    (thresh),
    .thresh_ce_i (ce),
    .update_i    (upd),
    .trigger_o   (trig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge and settle just past it
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_all(input logic [16:0] v);
    a0 = v; a1 = v; b0 = v; b1 = v;
  endtask

  task automatic load(input logic [1:0] c, input logic [17:0] v);
    thresh = v; ce = c;
    tick();
    ce = 2'b00;
  endtask

  task automatic do_update();
    upd = 1'b1;
    tick();
    upd = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_all(17'h1FFFF);
    thresh = '0; ce = 2'b00; upd = 1'b0;
    tick(2);
    n_cmp++;
    if (trig !== 2'b00) begin
      n_bad++; $display("FAIL reset_hold: got %b want 00", trig);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (trig !== 2'b00) begin
        n_bad++; $display("FAIL reset_noload cyc%0d: got %b want 00", i, trig);
      end
    end
  endtask

  task automatic test_sweep();
    logic [1:0] exp;
    load(2'b10, 18'd10);
    load(2'b01, 18'd20);
    do_update();
    for (int k = 0; k <= 30; k++) begin
      set_all(17'(k));
      tick(16);
      exp[1] = ((2 * k) > 10);
      exp[0] = ((2 * k) > 20);
      n_cmp++;
      if (trig !== exp) begin
        n_bad++; $display("FAIL sweep k=%0d: got %b want %b", k, trig, exp);
      end
    end
  endtask

  task automatic test_latency();
    logic [1:0] exp_seq [3];
    exp_seq[0] = 2'b00; exp_seq[1] = 2'b00; exp_seq[2] = 2'b11;
    set_all(17'd0);
    tick(6);
    set_all(17'd11);
    for (int e = 0; e < 3; e++) begin
      tick();
      n_cmp++;
      if (trig !== exp_seq[e]) begin
        n_bad++; $display("FAIL latency edge%0d: got %b want %b", e + 1, trig, exp_seq[e]);
      end
    end
  endtask

  task automatic test_extreme();
    load(2'b10, 18'h3FFFF);
    load(2'b01, 18'd0);
    do_update();
    set_all(17'd0);
    tick(5);
    n_cmp++;
    if (trig !== 2'b00) begin
      n_bad++; $display("FAIL extreme_zero: got %b want 00", trig);
    end
    set_all(17'd65535);
    tick(5);
    n_cmp++;
    if (trig !== 2'b01) begin
      n_bad++; $display("FAIL extreme_131070: got %b want 01", trig);
    end
    set_all(17'd65536);
    tick(5);
    n_cmp++;
    if (trig !== 2'b01) begin
      n_bad++; $display("FAIL extreme_131072: got %b want 01", trig);
    end
  endtask

  task automatic test_shadow();
    load(2'b10, 18'd10);
    load(2'b01, 18'd20);
    do_update();
    set_all(17'd3);          // sum 6: below both thresholds
    tick(5);
    n_cmp++;
    if (trig !== 2'b00) begin
      n_bad++; $display("FAIL shadow_pre: got %b want 00", trig);
    end
    load(2'b10, 18'd0);      // shadow only
    tick(4);
    n_cmp++;
    if (trig !== 2'b00) begin
      n_bad++; $display("FAIL shadow_noupd: got %b want 00", trig);
    end
    do_update();             // edge of update still compares with old active
    n_cmp++;
    if (trig !== 2'b00) begin
      n_bad++; $display("FAIL shadow_upd_edge: got %b want 00", trig);
    end
    tick();
    n_cmp++;
    if (trig !== 2'b10) begin
      n_bad++; $display("FAIL shadow_after_upd: got %b want 10", trig);
    end
  endtask

  task automatic test_midreset();
    load(2'b11, 18'd10);
    do_update();
    set_all(17'd15);
    tick(5);
    n_cmp++;
    if (trig !== 2'b11) begin
      n_bad++; $display("FAIL midrst_pre: got %b want 11", trig);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (trig !== 2'b00) begin
      n_bad++; $display("FAIL midrst_async: got %b want 00", trig);
    end
    tick(2);
    rst_n = 1'b1;
    tick(8);
    n_cmp++;
    if (trig !== 2'b00) begin
      n_bad++; $display("FAIL midrst_after_release: got %b want 00", trig);
    end
    load(2'b11, 18'd10);
    tick(4);
    n_cmp++;
    if (trig !== 2'b00) begin
      n_bad++; $display("FAIL midrst_load_noupd: got %b want 00", trig);
    end
    do_update();
    tick(2);
    n_cmp++;
    if (trig !== 2'b11) begin
      n_bad++; $display("FAIL midrst_reload: got %b want 11", trig);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_sweep();
    test_latency();
    test_extreme();
    test_shadow();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_dual_beam_thresh_trigger

`default_nettype wire
